// File: rtl/lsu_mem_port.sv
// lsu_mem_port: multicycle load/store port between the datapath and data memory.
//
// A start pulse in IDLE captures the access (is_store, funct3, addr, store_data).
// One CHECK cycle validates size and alignment. A legal access then runs a
// req/ack handshake in REQ, with the request fields held stable until ack.
// One RESP cycle pulses done with the fault code.
// Load data is lane-aligned, sign- or zero-extended, and registered into D_in,
// which feeds the bus_C writeback mux.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, is_store     request pulse (sampled only in IDLE), store/load select
//   funct3, addr        RV32I size/sign field, effective byte address
//   store_data          RS2 value to store
//   D_in                registered load result
//   done, fault, busy   completion pulse, fault code valid with done, busy flag
//   mem_req/we/addr/be/wdata, mem_rdata, mem_ack   memory handshake
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] D_in,
    output logic        done,
    output logic [1:0]  fault,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        REQ   = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      state_r, state_s;
    logic        is_store_r, is_store_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] store_data_r, store_data_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [31:0] d_in_s;
    logic        done_s, busy_s, mem_req_s, mem_we_s;
    logic [1:0]  fault_s;
    logic [31:0] mem_addr_s, mem_wdata_s;
    logic [3:0]  mem_be_s;

    // funct3 encodings this port accepts; LBU/LHU have no store counterpart
    function automatic logic size_legal(input logic st, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: size_legal = 1'b1;
            3'b100, 3'b101:         size_legal = ~st;
            default:                size_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << a;
            2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Replicate the datum across every lane so memory only needs the byte enables
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = rd;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus next value of every registered output and captured field
    always_comb begin
        state_s      = state_r;
        is_store_s   = is_store_r;
        funct3_s     = funct3_r;
        addr_s       = addr_r;
        store_data_s = store_data_r;
        cnt_s        = cnt_r;
        d_in_s       = D_in;
        fault_s      = 2'b00;
        mem_req_s    = mem_req;
        mem_we_s     = mem_we;
        mem_addr_s   = mem_addr;
        mem_be_s     = mem_be;
        mem_wdata_s  = mem_wdata;
        case (state_r)
            IDLE: begin
                if (start) begin
                    is_store_s   = is_store;
                    funct3_s     = funct3;
                    addr_s       = addr;
                    store_data_s = store_data;
                    state_s      = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                if (!size_legal(is_store_r, funct3_r)) begin
                    fault_s = 2'b11;
                    state_s = RESP;
                    d_in_s  = is_store_r ? D_in : 32'd0;
                end else if (misaligned(funct3_r, addr_r[1:0])) begin
                    fault_s = 2'b01;
                    state_s = RESP;
                    d_in_s  = is_store_r ? D_in : 32'd0;
                end else begin
                    state_s     = REQ;
                    cnt_s       = 8'd0;
                    mem_req_s   = 1'b1;
                    mem_we_s    = is_store_r;
                    mem_addr_s  = {addr_r[31:2], 2'b00};
                    mem_be_s    = lane_be(funct3_r, addr_r[1:0]);
                    mem_wdata_s = lane_wdata(funct3_r, store_data_r);
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_s     = RESP;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = 32'd0;
                    mem_be_s    = 4'd0;
                    mem_wdata_s = 32'd0;
                    d_in_s      = is_store_r ? D_in
                                             : load_extract(funct3_r, addr_r[1:0], mem_rdata);
                end else if ((cnt_r + 8'd1) == TIMEOUT_LIMIT) begin
                    state_s     = RESP;
                    fault_s     = 2'b10;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = 32'd0;
                    mem_be_s    = 4'd0;
                    mem_wdata_s = 32'd0;
                    d_in_s      = is_store_r ? D_in : 32'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        done_s = (state_s == RESP);
        busy_s = (state_s != IDLE);
    end

    // Captured access fields, wait counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_r   <= 1'b0;
            funct3_r     <= 3'd0;
            addr_r       <= 32'd0;
            store_data_r <= 32'd0;
            cnt_r        <= 8'd0;
            D_in         <= 32'd0;
            done         <= 1'b0;
            fault        <= 2'b00;
            busy         <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
        end else begin
            is_store_r   <= is_store_s;
            funct3_r     <= funct3_s;
            addr_r       <= addr_s;
            store_data_r <= store_data_s;
            cnt_r        <= cnt_s;
            D_in         <= d_in_s;
            done         <= done_s;
            fault        <= fault_s;
            busy         <= busy_s;
            mem_req      <= mem_req_s;
            mem_we       <= mem_we_s;
            mem_addr     <= mem_addr_s;
            mem_be       <= mem_be_s;
            mem_wdata    <= mem_wdata_s;
        end
    end

endmodule
